// File: rtl/mult_shift_add_if.sv
// Handshake and data bundle between the ALU and the shift-and-add multiplier.
// The ALU drives operands and the init level; the multiplier returns product and status.
interface mult_shift_add_if #(
  parameter int N = 3
);
  logic           init;
  logic [N-1:0]   MR;
  logic [N-1:0]   MD;
  logic [2*N-1:0] pp;
  logic           done;
  logic           busy;

  modport master (output init, MR, MD, input pp, done, busy);
  modport slave  (input init, MR, MD, output pp, done, busy);
endinterface

// File: rtl/mult_shift_add.sv
// Sequential unsigned shift-and-add multiplier started and held by a level init.
// Result and done are held in DONE until init is released; dropping init mid-run aborts.
module mult_shift_add #(
  parameter int N = 3
) (
  input  logic            clk,
  input  logic            rst,
  mult_shift_add_if.slave bus
);

  localparam int W = 2 * N;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ADD,
    SHIFT,
    DONE
  } state_t;

  state_t         state;
  logic [W-1:0]   acc;
  logic [W-1:0]   a;
  logic [N-1:0]   b;
  logic [W-1:0]   pp_q;
  logic           done_q;
  logic           busy_q;

  assign bus.pp   = pp_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;

  // NOTE: all state uses non-blocking assignments so every register updates from
  // pre-edge values; blocking here would let later statements see half-updated state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      a      <= '0;
      b      <= '0;
      pp_q   <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.init) begin
            a      <= {{N{1'b0}}, bus.MD};
            b      <= bus.MR;
            acc    <= '0;
            state  <= CHECK;
            busy_q <= 1'b1;
          end
        end

        CHECK: begin
          if (!bus.init) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (b == '0) begin
            pp_q   <= acc;
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else if (b[0]) begin
            state <= ADD;
          end else begin
            state <= SHIFT;
          end
        end

        ADD: begin
          if (!bus.init) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            acc   <= acc + a;
            state <= SHIFT;
          end
        end

        SHIFT: begin
          if (!bus.init) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            a     <= a << 1;
            b     <= b >> 1;
            state <= CHECK;
          end
        end

        DONE: begin
          // No restart while init stays high; a low sample is needed to re-arm.
          if (!bus.init) begin
            state  <= IDLE;
            done_q <= 1'b0;
          end
        end

        default: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
